smp8_imem_loader: RTL and testbench
===================================

Name: smp8_imem_loader

Overview:
- Byte-stream program loader that sits directly upstream of the SMP8 instruction memory and core.
- Receives a framed program over a valid/ready byte interface and writes it into imem words 0..N-1.
- Verifies an 8-bit checksum over the payload.
- Holds the core in reset until a frame loads without error; on success the core starts fetching at pc=0 from freshly loaded code.

Parameters:
- DEPTH, 64, imem words; the maximum payload length.
- AW, 6, imem address width; must equal clog2(DEPTH).
- HDR, 8'hA5, frame start byte.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data carries a byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte. A byte is accepted on a cycle where in_valid & in_ready.
- imem_we  output  1  imem write strobe, one cycle per payload byte.
- imem_addr  output  AW  imem write address.
- imem_wdata  output  8  imem write data.
- cpu_reset  output  1  drives the core's reset input; high means the core is held.
- load_done  output  1  the last frame loaded and checked successfully.
- load_err  output  1  the last frame was rejected.
- err_code  output  2  rejection reason: 00 none, 01 bad length, 10 bad checksum.

Behaviour:
- Reset is synchronous and active-high, per the already-decided interface.
- Reset values, for every cycle in which reset is high:
  - state=IDLE
  - in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0
  - cpu_reset=1, load_done=0, load_err=0, err_code=00
  - internal count and sum cleared to 0
- All outputs are registered. in_ready becomes 1 in the first cycle after reset deasserts and stays 1 in every state.
- State machine (each transition happens only on an accepted byte):
  - IDLE: byte==HDR goes to LEN and clears count/sum; any other byte is discarded and the state stays IDLE.
  - LEN:
    - byte is 0 or greater than DEPTH: go to ERR with err_code=01.
    - otherwise: latch len=byte and go to DATA.
  - DATA:
    - each accepted byte b produces, on the next cycle, imem_we=1, imem_addr=count, imem_wdata=b (write latency is 1 cycle).
    - sum <= sum + b (mod 256); count <= count + 1.
    - when count reaches len-1 (the last byte is accepted), go to CHK.
  - CHK:
    - byte==sum: go to DONE, with load_done=1, load_err=0, err_code=00.
    - otherwise: go to ERR with err_code=10.
  - DONE:
    - cpu_reset falls to 0 in the same cycle load_done rises.
    - byte==HDR: restart. cpu_reset=1 and load_done=0 from the next cycle, then go to LEN.
    - other bytes are ignored while the core runs.
  - ERR:
    - load_err=1 and cpu_reset=1.
    - byte==HDR clears load_err/err_code, then goes to LEN.
    - other bytes are discarded.
- cpu_reset is 1 in every state except DONE.
- imem_we is never asserted outside the cycle following an accepted DATA byte.
- Boundary conditions:
  - len=DEPTH writes addresses 0..DEPTH-1; imem_addr never wraps.
  - Words at addresses >= len are left untouched.
  - A byte equal to HDR inside LEN, DATA or CHK is treated as ordinary data, not as a restart.
  - in_valid low: the FSM holds state and counters, with no timeout.
  - reset mid-frame aborts the frame. Words already written stay in imem, the core stays held, and the FSM returns to IDLE.
  - A payload written by a failed frame is never executed, because cpu_reset stays 1.
  - Checksum is the 8-bit sum of payload bytes only; the length and header bytes are excluded.

Decomposition:
- Shared package smp8_pkg: loader_state_t enum (IDLE, LEN, DATA, CHK, DONE, ERR), the HDR constant, and the err_code constants ERR_NONE, ERR_LEN, ERR_CSUM.
- No sub-module is required. The checksum accumulator stays inline.

Test Plan:
- Minimal frame: stream A5 03 15 2A 80 BF (sum 15+2A+80=BF) -> imem[0..2]=15,2A,80; three single-cycle imem_we pulses at addr 0,1,2; then load_done=1 and cpu_reset=0.
- Bad checksum: A5 02 10 20 31 -> load_err=1, err_code=10, cpu_reset stays 1. Then a correct frame A5 01 55 55 -> load_done=1 and err cleared.
- Length bounds:
  - A5 00 -> err_code=01 with no imem_we.
  - A5 41 -> err_code=01.
  - A5 40 followed by 64 bytes plus the correct checksum -> writes to addresses 0..63 with no wrap, then load_done.
- Garbage and backpressure: 11 22 before A5, and in_valid dropped for 5 cycles mid-DATA -> leading bytes ignored, count and sum preserved, load succeeds; A5 as a payload byte is stored, not treated as a restart.
- Reset mid-DATA after 2 of 4 bytes -> next cycle IDLE, cpu_reset=1, imem_we=0. The full frame then resent loads correctly.
- Reload from DONE: after a successful load, send A5 -> cpu_reset=1 and load_done=0 the following cycle; the second frame then completes with cpu_reset=0.

Source files
------------

// File: rtl/smp8_pkg.sv
// Shared types and constants for the SMP8 program loader.
// Holds the loader FSM encoding, the frame header byte and the rejection codes.
package smp8_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CHK  = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } loader_state_t;

  localparam logic [7:0] HDR = 8'hA5;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;

  // Running payload checksum: plain 8-bit modular sum.
  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

endpackage

// File: rtl/smp8_imem_loader_if.sv
// Byte-stream input and imem write port of the SMP8 program loader.
// The master drives the stream and consumes imem writes; the slave is the loader.
interface smp8_imem_loader_if #(
  parameter int AW = 6
);

  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [7:0]    imem_wdata;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

endinterface

// File: rtl/smp8_imem_loader.sv
// Framed byte-stream loader for SMP8 instruction memory: HDR, length, payload, checksum.
// Keeps the core in reset until a frame has been written and its checksum verified.
module smp8_imem_loader #(
  parameter int         DEPTH = 64,
  parameter int         AW    = 6,
  parameter logic [7:0] HDR   = smp8_pkg::HDR
) (
  input  logic                clk,
  input  logic                reset,
  smp8_imem_loader_if.slave   bus,
  output logic                cpu_reset,
  output logic                load_done,
  output logic                load_err,
  output logic [1:0]          err_code
);

  import smp8_pkg::*;

  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [7:0]  DEPTH_B = 8'(DEPTH);

  loader_state_t state_r;
  loader_state_t state_nxt_s;

  logic [AW:0]   count_r;
  logic [AW:0]   len_r;
  logic [7:0]    sum_r;

  logic          in_ready_r;
  logic          imem_we_r;
  logic [AW-1:0] imem_addr_r;
  logic [7:0]    imem_wdata_r;
  logic          cpu_reset_r;
  logic          load_done_r;
  logic          load_err_r;
  logic [1:0]    err_code_r;

  logic          accept_s;
  logic          is_hdr_s;
  logic          len_bad_s;
  logic          last_s;
  logic          csum_ok_s;
  logic          we_nxt_s;
  logic [1:0]    err_code_nxt_s;

  assign accept_s  = bus.in_valid & in_ready_r;
  assign is_hdr_s  = (bus.in_data == HDR);
  assign len_bad_s = (bus.in_data == 8'd0) || (bus.in_data > DEPTH_B);
  assign last_s    = (count_r == (len_r - CNT_ONE));
  assign csum_ok_s = (bus.in_data == sum_r);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; every transition is gated by an accepted byte.
  always_comb begin
    state_nxt_s = state_r;
    if (accept_s) begin
      case (state_r)
        IDLE: begin
          if (is_hdr_s) begin
            state_nxt_s = LEN;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        LEN: begin
          if (len_bad_s) begin
            state_nxt_s = ERR;
          end else begin
            state_nxt_s = DATA;
          end
        end
        DATA: begin
          if (last_s) begin
            state_nxt_s = CHK;
          end else begin
            state_nxt_s = DATA;
          end
        end
        CHK: begin
          if (csum_ok_s) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = ERR;
          end
        end
        DONE, ERR: begin
          if (is_hdr_s) begin
            state_nxt_s = LEN;
          end else begin
            state_nxt_s = state_r;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Output decode; status follows the state being entered so it lines up with it.
  always_comb begin
    we_nxt_s       = accept_s && (state_r == DATA);
    err_code_nxt_s = err_code_r;
    case (state_nxt_s)
      ERR: begin
        if (state_r == LEN) begin
          err_code_nxt_s = ERR_LEN;
        end else if (state_r == CHK) begin
          err_code_nxt_s = ERR_CSUM;
        end else begin
          err_code_nxt_s = err_code_r;
        end
      end
      default: begin
        err_code_nxt_s = ERR_NONE;
      end
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready_r   <= 1'b0;
      imem_we_r    <= 1'b0;
      imem_addr_r  <= {AW{1'b0}};
      imem_wdata_r <= 8'd0;
      cpu_reset_r  <= 1'b1;
      load_done_r  <= 1'b0;
      load_err_r   <= 1'b0;
      err_code_r   <= ERR_NONE;
    end else begin
      in_ready_r <= 1'b1;
      imem_we_r  <= we_nxt_s;
      if (we_nxt_s) begin
        imem_addr_r  <= count_r[AW-1:0];
        imem_wdata_r <= bus.in_data;
      end else begin
        imem_addr_r  <= imem_addr_r;
        imem_wdata_r <= imem_wdata_r;
      end
      cpu_reset_r <= (state_nxt_s != DONE);
      load_done_r <= (state_nxt_s == DONE);
      load_err_r  <= (state_nxt_s == ERR);
      err_code_r  <= err_code_nxt_s;
    end
  end

  // Frame length, payload count and checksum accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {(AW+1){1'b0}};
      len_r   <= {(AW+1){1'b0}};
      sum_r   <= 8'd0;
    end else if (accept_s) begin
      case (state_r)
        IDLE, DONE, ERR: begin
          if (is_hdr_s) begin
            count_r <= {(AW+1){1'b0}};
            sum_r   <= 8'd0;
          end else begin
            count_r <= count_r;
            sum_r   <= sum_r;
          end
        end
        LEN: begin
          if (!len_bad_s) begin
            len_r <= bus.in_data[AW:0];
          end else begin
            len_r <= len_r;
          end
        end
        DATA: begin
          count_r <= count_r + CNT_ONE;
          sum_r   <= csum_add(sum_r, bus.in_data);
        end
        default: begin
          count_r <= count_r;
          len_r   <= len_r;
          sum_r   <= sum_r;
        end
      endcase
    end else begin
      count_r <= count_r;
      len_r   <= len_r;
      sum_r   <= sum_r;
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.imem_we    = imem_we_r;
  assign bus.imem_addr  = imem_addr_r;
  assign bus.imem_wdata = imem_wdata_r;
  assign cpu_reset      = cpu_reset_r;
  assign load_done      = load_done_r;
  assign load_err       = load_err_r;
  assign err_code       = err_code_r;

endmodule

// File: tb/tb_smp8_imem_loader.sv
// Self-checking bench for smp8_imem_loader: imem writes are scoreboarded,
// status outputs are checked against the frame outcome after each frame.
module tb_smp8_imem_loader;

  import smp8_pkg::*;

  logic       clk;
  logic       reset;
  logic       cpu_reset;
  logic       load_done;
  logic       load_err;
  logic [1:0] err_code;

  int total;
  int bad;
  int we_cnt;

  logic [13:0] exp_q[$];
  logic [7:0]  pl_q[$];

  smp8_imem_loader_if #(.AW(6)) bus ();

  smp8_imem_loader #(.DEPTH(64), .AW(6), .HDR(8'hA5)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .cpu_reset (cpu_reset),
    .load_done (load_done),
    .load_err  (load_err),
    .err_code  (err_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Write monitor: every imem write must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      we_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("spurious_we", 32'(bus.imem_we), 32'd0);
      end else begin
        logic [13:0] e;
        e = exp_q.pop_front();
        check_eq("wr_addr", 32'(bus.imem_addr), 32'(e[13:8]));
        check_eq("wr_data", 32'(bus.imem_wdata), 32'(e[7:0]));
      end
    end
  end

  // Called at a negedge; returns at the next negedge after the byte was presented.
  task automatic send_byte(input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Sends [HDR] len payload csum from pl_q; queues the expected imem writes.
  task automatic send_frame(input logic corrupt, input int gap_at, input logic with_hdr);
    logic [7:0] s;
    s = 8'd0;
    if (with_hdr) send_byte(HDR);
    send_byte(8'(pl_q.size()));
    for (int i = 0; i < pl_q.size(); i++) begin
      if (i == gap_at) begin
        idle(5);
        check_eq("gap_no_we", 32'(bus.imem_we), 32'd0);
        check_eq("gap_not_done", 32'(load_done), 32'd0);
      end
      exp_q.push_back({6'(i), pl_q[i]});
      s = s + pl_q[i];
      send_byte(pl_q[i]);
    end
    send_byte(corrupt ? (s ^ 8'h01) : s);
  endtask

  task automatic expect_done(input string tag);
    check_eq({tag, "_done"}, 32'(load_done), 32'd1);
    check_eq({tag, "_cpurst"}, 32'(cpu_reset), 32'd0);
    check_eq({tag, "_err"}, 32'(load_err), 32'd0);
    check_eq({tag, "_code"}, 32'(err_code), 32'(ERR_NONE));
  endtask

  task automatic expect_err(input string tag, input logic [1:0] code);
    check_eq({tag, "_done"}, 32'(load_done), 32'd0);
    check_eq({tag, "_cpurst"}, 32'(cpu_reset), 32'd1);
    check_eq({tag, "_err"}, 32'(load_err), 32'd1);
    check_eq({tag, "_code"}, 32'(err_code), 32'(code));
  endtask

  initial begin
    int w0;
    total        = 0;
    bad          = 0;
    we_cnt       = 0;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);

    // Reset values
    check_eq("rst_ready", 32'(bus.in_ready), 32'd0);
    check_eq("rst_we", 32'(bus.imem_we), 32'd0);
    check_eq("rst_addr", 32'(bus.imem_addr), 32'd0);
    check_eq("rst_wdata", 32'(bus.imem_wdata), 32'd0);
    check_eq("rst_cpurst", 32'(cpu_reset), 32'd1);
    check_eq("rst_done", 32'(load_done), 32'd0);
    check_eq("rst_err", 32'(load_err), 32'd0);
    check_eq("rst_code", 32'(err_code), 32'd0);
    reset = 1'b0;
    idle(1);
    check_eq("ready_after_rst", 32'(bus.in_ready), 32'd1);

    // Minimal frame A5 03 15 2A 80 BF
    send_byte(HDR);
    send_byte(8'h03);
    exp_q.push_back({6'd0, 8'h15}); send_byte(8'h15);
    exp_q.push_back({6'd1, 8'h2A}); send_byte(8'h2A);
    exp_q.push_back({6'd2, 8'h80}); send_byte(8'h80);
    send_byte(8'hBF);
    expect_done("min");
    check_eq("min_wecnt", 32'(we_cnt), 32'd3);

    // Bad checksum A5 02 10 20 31, then A5 01 55 55
    pl_q = '{8'h10, 8'h20};
    send_frame(1'b1, -1, 1'b1);
    expect_err("csum", ERR_CSUM);
    pl_q = '{8'h55};
    send_frame(1'b0, -1, 1'b1);
    expect_done("after_csum");

    // Length bounds
    w0 = we_cnt;
    send_byte(HDR);
    send_byte(8'h00);
    expect_err("len0", ERR_LEN);
    idle(2);
    check_eq("len0_no_we", 32'(we_cnt), 32'(w0));
    send_byte(HDR);
    send_byte(8'h41);
    expect_err("len41", ERR_LEN);
    idle(2);
    check_eq("len41_no_we", 32'(we_cnt), 32'(w0));
    pl_q.delete();
    for (int i = 0; i < 64; i++) pl_q.push_back(8'((i * 37 + 11) & 8'hFF));
    send_frame(1'b0, -1, 1'b1);
    expect_done("len64");
    check_eq("len64_wecnt", 32'(we_cnt - w0), 32'd64);

    // Bytes while running are ignored
    send_byte(8'h11);
    send_byte(8'h22);
    idle(2);
    expect_done("run_ignore");

    // Backpressure gap mid-DATA, HDR as payload byte
    pl_q = '{HDR, 8'h3C, 8'h5A, 8'h07};
    send_frame(1'b0, 2, 1'b1);
    expect_done("gap");

    // Reset mid-DATA after 2 of 4 bytes
    send_byte(HDR);
    send_byte(8'h04);
    exp_q.push_back({6'd0, 8'h01}); send_byte(8'h01);
    exp_q.push_back({6'd1, 8'h02}); send_byte(8'h02);
    reset = 1'b1;
    @(negedge clk);
    check_eq("midrst_cpurst", 32'(cpu_reset), 32'd1);
    check_eq("midrst_we", 32'(bus.imem_we), 32'd0);
    check_eq("midrst_done", 32'(load_done), 32'd0);
    reset = 1'b0;
    idle(1);
    send_byte(8'h11);
    send_byte(8'h22);
    idle(1);
    check_eq("garbage_cpurst", 32'(cpu_reset), 32'd1);
    check_eq("garbage_no_err", 32'(load_err), 32'd0);
    pl_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(1'b0, -1, 1'b1);
    expect_done("resend");

    // Reload from DONE; checksum byte equals HDR
    send_byte(HDR);
    check_eq("reload_cpurst", 32'(cpu_reset), 32'd1);
    check_eq("reload_done", 32'(load_done), 32'd0);
    pl_q = '{8'hA0, 8'h05};
    send_frame(1'b0, -1, 1'b0);
    expect_done("reload");

    idle(3);
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
